// File: rtl/control_sequencer_if.sv
// Handshake bundle between the CPU control path and control_sequencer.
// master: drives decoder flags, run enable, memory completion and stall.
// slave:  the sequencer; returns its phase vector, status and counters.
interface control_sequencer_if #(
  parameter int CNT_W = 32
);
  logic             en;
  logic [2:0]       func;
  logic             halt;
  logic             mem_done;
  logic             stall;
  logic [9:0]       state;
  logic             busy;
  logic             err;
  logic             instr_done;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] retired_cnt;

  modport master (
    output en, func, halt, mem_done, stall,
    input  state, busy, err, instr_done, cycle_cnt, retired_cnt
  );

  modport slave (
    input  en, func, halt, mem_done, stall,
    output state, busy, err, instr_done, cycle_cnt, retired_cnt
  );
endinterface

// File: rtl/control_sequencer.sv
// Multi-cycle instruction sequencer driving one-hot phase enables.
// Phases: IDLE, FETCH (wait-stated), DECODE, EXEC_ALU/MEM/BR, STALL, PC_UPD,
// plus sticky HALTED and FAULT that only the asynchronous reset leaves.
// Optional performance counters are built when SEQ_PERF_CNT_EN is defined;
// otherwise cycle_cnt/retired_cnt are constant zero.
module control_sequencer #(
  parameter int FETCH_WAIT  = 1,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic clk,
  input  logic rst,
  control_sequencer_if.slave bus
);

  typedef enum logic [9:0] {
    S_IDLE     = 10'b00_0000_0001,
    S_FETCH    = 10'b00_0000_0010,
    S_DECODE   = 10'b00_0000_0100,
    S_EXEC_ALU = 10'b00_0000_1000,
    S_EXEC_MEM = 10'b00_0001_0000,
    S_EXEC_BR  = 10'b00_0010_0000,
    S_STALL    = 10'b00_0100_0000,
    S_PC_UPD   = 10'b00_1000_0000,
    S_HALTED   = 10'b01_0000_0000,
    S_FAULT    = 10'b10_0000_0000
  } state_t;

  // FETCH lasts at least one cycle even when FETCH_WAIT is 0.
  localparam int                FETCH_CYC = (FETCH_WAIT > 1) ? FETCH_WAIT : 1;
  localparam int                WAIT_W    = (FETCH_CYC > 1) ? $clog2(FETCH_CYC) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(FETCH_CYC - 1);
  localparam int                TO_W      = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);
  localparam bit                TO_EN     = (MEM_TIMEOUT != 0);

  state_t            r_state;
  state_t            w_next;
  logic [WAIT_W-1:0] r_wait;
  logic [TO_W-1:0]   r_to;
  logic              r_busy;
  logic              r_err;
  logic              r_done;

  // Next-phase selection from the current phase and the sampled inputs.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:     if (bus.en) w_next = S_FETCH;
      S_FETCH:    if (r_wait == WAIT_LAST) w_next = S_DECODE;
      S_DECODE: begin
        if (bus.halt) begin
          w_next = S_HALTED;
        end else begin
          unique case (bus.func)
            3'b000:  w_next = S_EXEC_ALU;
            3'b001:  w_next = S_EXEC_MEM;
            3'b010:  w_next = S_EXEC_BR;
            default: w_next = S_FAULT;
          endcase
        end
      end
      S_EXEC_ALU: w_next = S_PC_UPD;
      S_EXEC_BR:  w_next = S_PC_UPD;
      // Completion wins over a timeout landing on the same cycle.
      S_EXEC_MEM: begin
        if (bus.mem_done)                     w_next = S_PC_UPD;
        else if (TO_EN && (r_to == TO_LAST))  w_next = S_FAULT;
      end
      S_PC_UPD: begin
        if (bus.stall)   w_next = S_STALL;
        else if (bus.en) w_next = S_FETCH;
        else             w_next = S_IDLE;
      end
      S_STALL:    if (!bus.stall) w_next = bus.en ? S_FETCH : S_IDLE;
      S_HALTED:   w_next = S_HALTED;
      S_FAULT:    w_next = S_FAULT;
      // A corrupted encoding is treated as a fault rather than guessed at.
      default:    w_next = S_FAULT;
    endcase
  end

  // Phase register, wait/timeout counters and status outputs registered together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_wait  <= '0;
      r_to    <= '0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      // Counters sit at zero outside their phase, so each entry starts from 0.
      r_wait  <= ((r_state == S_FETCH) && (w_next == S_FETCH)) ? r_wait + 1'b1 : '0;
      r_to    <= (r_state == S_EXEC_MEM) ? r_to + 1'b1 : '0;
      r_busy  <= !(w_next inside {S_IDLE, S_HALTED, S_FAULT});
      r_err   <= (w_next == S_FAULT);
      r_done  <= (w_next == S_PC_UPD);
    end
  end

  assign bus.state      = r_state;
  assign bus.busy       = r_busy;
  assign bus.err        = r_err;
  assign bus.instr_done = r_done;

`ifdef SEQ_PERF_CNT_EN
  logic [CNT_W-1:0] r_cycle_cnt;
  logic [CNT_W-1:0] r_retired_cnt;

  // Saturating active-cycle and retired-instruction counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cycle_cnt   <= '0;
      r_retired_cnt <= '0;
    end else begin
      if (r_busy && (r_cycle_cnt != '1))
        r_cycle_cnt <= r_cycle_cnt + 1'b1;
      if ((r_state == S_PC_UPD) && (r_retired_cnt != '1))
        r_retired_cnt <= r_retired_cnt + 1'b1;
    end
  end

  assign bus.cycle_cnt   = r_cycle_cnt;
  assign bus.retired_cnt = r_retired_cnt;
`else
  assign bus.cycle_cnt   = '0;
  assign bus.retired_cnt = '0;
`endif

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: a vector table for the basic phase
// walk on a FETCH_WAIT=1 instance, then hand sequences for wait-states,
// memory completion/timeout, sticky states, stall, async reset and counters.
module tb_control_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en, halt, mem_done, stall;
  logic [2:0] func;

  always #5 clk = ~clk;

  control_sequencer_if #(.CNT_W(32)) if1 ();
  control_sequencer_if #(.CNT_W(32)) if3 ();

  assign if1.en = en;  assign if1.func = func;  assign if1.halt = halt;
  assign if1.mem_done = mem_done;  assign if1.stall = stall;
  assign if3.en = en;  assign if3.func = func;  assign if3.halt = halt;
  assign if3.mem_done = mem_done;  assign if3.stall = stall;

  control_sequencer #(.FETCH_WAIT(1), .MEM_TIMEOUT(15), .CNT_W(32)) dut1 (
    .clk(clk), .rst(rst), .bus(if1)
  );
  control_sequencer #(.FETCH_WAIT(3), .MEM_TIMEOUT(15), .CNT_W(32)) dut3 (
    .clk(clk), .rst(rst), .bus(if3)
  );

  localparam logic [9:0] IDLE = 10'h001, FETCH = 10'h002, DECODE = 10'h004,
                         EALU = 10'h008, EMEM = 10'h010, EBR = 10'h020,
                         STALL = 10'h040, PCUPD = 10'h080, HALTED = 10'h100,
                         FAULT = 10'h200;
  // flags = {busy, err, instr_done}
  localparam logic [2:0] F_OFF = 3'b000, F_BSY = 3'b100, F_DONE = 3'b101,
                         F_ERR = 3'b010;

`ifdef SEQ_PERF_CNT_EN
  localparam int EXP_CYC = 40;
  localparam int EXP_RET = 10;
`else
  localparam int EXP_CYC = 0;
  localparam int EXP_RET = 0;
`endif

  typedef struct {
    logic       en;
    logic [2:0] func;
    logic       halt;
    logic       mem_done;
    logic       stall;
    logic [9:0] st;
    logic [2:0] flags;
  } vec_t;

  vec_t tbl[$];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic add(input logic e, input logic [2:0] f, input logic h,
                     input logic m, input logic s, input logic [9:0] st,
                     input logic [2:0] fl);
    vec_t v;
    v.en = e; v.func = f; v.halt = h; v.mem_done = m; v.stall = s;
    v.st = st; v.flags = fl;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string nm, input logic [9:0] st, input logic [2:0] fl);
    check({nm, " state"}, 32'(if1.state), 32'(st));
    check({nm, " flags"}, 32'({if1.busy, if1.err, if1.instr_done}), 32'(fl));
  endtask

  task automatic do_reset();
    en = 1'b0; func = 3'b000; halt = 1'b0; mem_done = 1'b0; stall = 1'b0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got running, expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] exp3 [7];

    en = 1'b0; func = 3'b000; halt = 1'b0; mem_done = 1'b0; stall = 1'b0;
    rst = 1'b0;
    tick();
    tick();
    chk1("reset", IDLE, F_OFF);
    check("reset cycle_cnt", if1.cycle_cnt, 32'd0);
    check("reset retired_cnt", if1.retired_cnt, 32'd0);
    rst = 1'b1;

    // en, func, halt, mem_done, stall -> state, flags after the next edge
    add(1'b1, 3'b000, 1'b0, 1'b0, 1'b0, FETCH,  F_BSY);
    add(1'b1, 3'b000, 1'b0, 1'b0, 1'b0, DECODE, F_BSY);
    add(1'b1, 3'b000, 1'b0, 1'b0, 1'b0, EALU,   F_BSY);
    add(1'b1, 3'b000, 1'b0, 1'b0, 1'b0, PCUPD,  F_DONE);
    add(1'b1, 3'b010, 1'b0, 1'b0, 1'b0, FETCH,  F_BSY);
    add(1'b1, 3'b010, 1'b0, 1'b0, 1'b0, DECODE, F_BSY);
    add(1'b1, 3'b010, 1'b0, 1'b0, 1'b0, EBR,    F_BSY);
    add(1'b1, 3'b010, 1'b0, 1'b0, 1'b0, PCUPD,  F_DONE);
    add(1'b1, 3'b001, 1'b0, 1'b0, 1'b0, FETCH,  F_BSY);
    add(1'b1, 3'b001, 1'b0, 1'b0, 1'b0, DECODE, F_BSY);
    add(1'b1, 3'b001, 1'b0, 1'b0, 1'b0, EMEM,   F_BSY);
    add(1'b1, 3'b001, 1'b0, 1'b0, 1'b0, EMEM,   F_BSY);
    add(1'b1, 3'b001, 1'b0, 1'b1, 1'b0, PCUPD,  F_DONE);
    add(1'b1, 3'b001, 1'b0, 1'b0, 1'b1, STALL,  F_BSY);
    add(1'b1, 3'b001, 1'b0, 1'b0, 1'b1, STALL,  F_BSY);
    add(1'b1, 3'b000, 1'b0, 1'b0, 1'b0, FETCH,  F_BSY);
    add(1'b1, 3'b000, 1'b0, 1'b0, 1'b0, DECODE, F_BSY);
    add(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, EALU,   F_BSY);
    add(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, PCUPD,  F_DONE);
    add(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, IDLE,   F_OFF);
    add(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, IDLE,   F_OFF);
    add(1'b1, 3'b000, 1'b0, 1'b0, 1'b0, FETCH,  F_BSY);
    add(1'b1, 3'b000, 1'b0, 1'b0, 1'b0, DECODE, F_BSY);
    add(1'b1, 3'b111, 1'b1, 1'b0, 1'b0, HALTED, F_OFF);
    add(1'b1, 3'b000, 1'b0, 1'b1, 1'b1, HALTED, F_OFF);
    add(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, HALTED, F_OFF);

    foreach (tbl[i]) begin
      en = tbl[i].en; func = tbl[i].func; halt = tbl[i].halt;
      mem_done = tbl[i].mem_done; stall = tbl[i].stall;
      tick();
      chk1($sformatf("vec%0d", i), tbl[i].st, tbl[i].flags);
    end

    // Three-cycle fetch on the wait-stated instance, branch instruction.
    do_reset();
    en = 1'b1; func = 3'b010;
    exp3[0] = FETCH; exp3[1] = FETCH; exp3[2] = FETCH; exp3[3] = DECODE;
    exp3[4] = EBR;   exp3[5] = PCUPD; exp3[6] = FETCH;
    for (int k = 0; k < 7; k++) begin
      tick();
      check($sformatf("fw3 step%0d state", k), 32'(if3.state), 32'(exp3[k]));
      check($sformatf("fw3 step%0d done", k), 32'(if3.instr_done),
            32'(exp3[k] == PCUPD));
    end

    // Memory completion on the fifth EXEC_MEM cycle.
    do_reset();
    en = 1'b1; func = 3'b001;
    tick(); tick(); tick();
    chk1("mem5 c1", EMEM, F_BSY);
    for (int k = 2; k <= 5; k++) begin
      tick();
      check($sformatf("mem5 c%0d state", k), 32'(if1.state), 32'(EMEM));
    end
    mem_done = 1'b1;
    tick();
    chk1("mem5 done", PCUPD, F_DONE);
    en = 1'b0; mem_done = 1'b0;
    tick();
    chk1("mem5 idle", IDLE, F_OFF);

    // Timeout after 15 EXEC_MEM cycles, then FAULT is sticky.
    do_reset();
    en = 1'b1; func = 3'b001;
    tick(); tick(); tick();
    for (int k = 2; k <= 15; k++) tick();
    chk1("tmo c15", EMEM, F_BSY);
    tick();
    chk1("tmo fault", FAULT, F_ERR);
    for (int k = 0; k < 6; k++) begin
      en = (k % 2 == 0) ? 1'b0 : 1'b1;
      stall = (k % 3 == 0) ? 1'b1 : 1'b0;
      mem_done = 1'b1;
      tick();
      chk1($sformatf("fault sticky%0d", k), FAULT, F_ERR);
    end
    do_reset();
    chk1("fault rst", IDLE, F_OFF);

    // mem_done on the very cycle the timeout would fire.
    en = 1'b1; func = 3'b001;
    tick(); tick(); tick();
    for (int k = 2; k <= 15; k++) tick();
    mem_done = 1'b1;
    tick();
    chk1("tmo prio", PCUPD, F_DONE);

    // Illegal instruction class.
    do_reset();
    en = 1'b1; func = 3'b111;
    tick(); tick(); tick();
    chk1("illegal", FAULT, F_ERR);

    // Stall held for four cycles after PC_UPD.
    do_reset();
    en = 1'b1; func = 3'b000;
    tick(); tick(); tick(); tick();
    chk1("stall pcupd", PCUPD, F_DONE);
    stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk1($sformatf("stall c%0d", k), STALL, F_BSY);
    end
    stall = 1'b0;
    tick();
    chk1("stall exit", FETCH, F_BSY);

    // Asynchronous reset in the middle of EXEC_MEM.
    do_reset();
    en = 1'b1; func = 3'b001;
    tick(); tick(); tick(); tick();
    chk1("arst pre", EMEM, F_BSY);
    #2;
    rst = 1'b0;
    #1;
    chk1("arst now", IDLE, F_OFF);
    check("arst cycle_cnt", if1.cycle_cnt, 32'd0);
    check("arst retired_cnt", if1.retired_cnt, 32'd0);

    // Ten ALU instructions back to back, then idle.
    do_reset();
    en = 1'b1; func = 3'b000;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 9) en = 1'b0;
      tick(); tick(); tick();
    end
    tick();
    chk1("perf idle", IDLE, F_OFF);
    check("perf cycle_cnt", if1.cycle_cnt, 32'(EXP_CYC));
    check("perf retired_cnt", if1.retired_cnt, 32'(EXP_RET));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
